// File: rtl/pio_read_scheduler_if.sv
// Signal bundle between the requesters / PIO slave and pio_read_scheduler.
interface pio_read_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 20
);
    // req is a level held until its rsp_valid/gnt pulse; rsp_valid and change_valid are one-cycle
    // pulses with no back-pressure; avm_read is a one-cycle strobe and the slave never stalls.
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_data;
    logic [1:0]         avm_address;
    logic               avm_read;
    logic [31:0]        avm_readdata;
    logic               poll_en;
    logic               change_valid;
    logic [DATA_W-1:0]  change_data;
    logic [DATA_W-1:0]  change_mask;

    modport slave (
        input  req, avm_readdata, poll_en,
        output gnt, rsp_valid, rsp_data, avm_address, avm_read,
               change_valid, change_data, change_mask
    );

    modport master (
        output req, avm_readdata, poll_en,
        input  gnt, rsp_valid, rsp_data, avm_address, avm_read,
               change_valid, change_data, change_mask
    );
endinterface

// File: rtl/pio_read_scheduler.sv
// Shares one PIO input slave among NUM_REQ requesters plus a periodic poll slot,
// round-robin, and reports bit changes between consecutive poll results.
module pio_read_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 20,
    parameter int READ_LATENCY = 1,
    parameter int POLL_DIV     = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    pio_read_scheduler_if.slave  bus,
    output logic [1:0]           dbg_state_o
);
    localparam int SLOTS = NUM_REQ + 1;
    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int CNT_W = $clog2(POLL_DIV);
    localparam logic [PTR_W-1:0] POLL_SLOT = PTR_W'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
    logic              poll_pend_q, poll_pend_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] last_poll_q, last_poll_d;

    logic [SLOTS-1:0]  pending;
    logic              found;
    logic [PTR_W-1:0]  pick;
    logic              expire;
    logic              win_is_poll;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= SLOTS) s = s - SLOTS;
        return PTR_W'(s);
    endfunction

    assign pending          = {poll_pend_q, bus.req};
    assign win_is_poll      = (win_q == POLL_SLOT);
    assign bus.avm_address  = 2'b00;
    assign dbg_state_o      = state_q;

    generate
        if (DATA_W < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^bus.avm_readdata[31:DATA_W];
        end
    endgenerate

    // First pending slot at or after the pointer, wrapping over all slots.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int k = 0; k < SLOTS; k++) begin
            if (!found && pending[wrap_add(rr_q, k)]) begin
                found = 1'b1;
                pick  = wrap_add(rr_q, k);
            end
        end
    end

    always_comb begin
        expire     = 1'b0;
        poll_cnt_d = poll_cnt_q;
        if (!bus.poll_en) begin
            poll_cnt_d = CNT_W'(POLL_DIV - 1);
        end else if (poll_cnt_q == '0) begin
            expire     = 1'b1;
            poll_cnt_d = CNT_W'(POLL_DIV - 1);
        end else begin
            poll_cnt_d = poll_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        win_d            = win_q;
        lat_d            = lat_q;
        cap_d            = cap_q;
        last_poll_d      = last_poll_q;
        poll_pend_d      = poll_pend_q;
        bus.avm_read     = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.gnt          = '0;
        bus.rsp_data     = '0;
        bus.change_valid = 1'b0;
        bus.change_data  = '0;
        bus.change_mask  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.avm_read = 1'b1;
                lat_d        = LAT_W'(READ_LATENCY);
                state_d      = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    cap_d   = bus.avm_readdata[DATA_W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_d    = win_is_poll ? '0 : win_q + PTR_W'(1);
                state_d = IDLE;
                if (win_is_poll) begin
                    poll_pend_d = 1'b0;
                    last_poll_d = cap_q;
                    if (cap_q != last_poll_q) begin
                        bus.change_valid = 1'b1;
                        bus.change_data  = cap_q;
                        bus.change_mask  = cap_q ^ last_poll_q;
                    end
                end else begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data  = cap_q;
                    for (int i = 0; i < NUM_REQ; i++) bus.gnt[i] = (win_q == PTR_W'(i));
                end
            end
            default: state_d = IDLE;
        endcase
        // A poll already granted runs to completion; a fresh expiry beats any clear.
        if (!bus.poll_en && !(state_q != IDLE && win_is_poll)) poll_pend_d = 1'b0;
        if (expire) poll_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            lat_q       <= '0;
            poll_cnt_q  <= CNT_W'(POLL_DIV - 1);
            poll_pend_q <= 1'b0;
            cap_q       <= '0;
            last_poll_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            lat_q       <= lat_d;
            poll_cnt_q  <= poll_cnt_d;
            poll_pend_q <= poll_pend_d;
            cap_q       <= cap_d;
            last_poll_q <= last_poll_d;
        end
    end
endmodule

// File: tb/tb_pio_read_scheduler.sv
// Bench for pio_read_scheduler: directed scenarios then random traffic, all checked
// cycle by cycle against a timestamp-based transaction model.
module tb_pio_read_scheduler;
    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 20;
    localparam int RL       = 1;
    localparam int POLL_DIV = 8;
    localparam int SLOTS    = NUM_REQ + 1;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] dbg_state;
    logic [DATA_W-1:0] in_port;

    pio_read_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus();

    pio_read_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .READ_LATENCY(RL), .POLL_DIV(POLL_DIV)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // PIO slave: registered readdata, junk in upper bits and outside read-response cycles.
    always @(posedge clk) begin
        if (bus.avm_read) bus.avm_readdata <= {12'($urandom), in_port};
        else              bus.avm_readdata <= $urandom;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: an access occupies RL+3 cycles starting at the arbitration cycle.
    int m_issue_at = -1;
    int m_done_at  = -1;
    int m_free_at  = 0;
    int m_win      = 0;
    int m_rr       = 0;
    int m_cnt      = POLL_DIV - 1;
    bit m_pend     = 1'b0;
    logic [DATA_W-1:0] m_last = '0;
    logic [DATA_W-1:0] exp_q[$];

    logic [NUM_REQ-1:0] rsp_seen = '0;
    int gnt_cnt[NUM_REQ];
    int chg_cnt  = 0;
    int rsp_cnt  = 0;
    logic [DATA_W-1:0] last_mask = '0;

    always @(negedge clk) begin
        bit e_read, e_done, e_ext, e_poll, e_chg, poll_busy, found;
        logic [DATA_W-1:0] got;
        logic [SLOTS-1:0] pend_vec;
        int s;
        got    = '0;
        e_read = (cyc == m_issue_at);
        e_done = (cyc == m_done_at);
        e_ext  = e_done && (m_win < NUM_REQ);
        e_poll = e_done && (m_win == NUM_REQ);
        if (e_done && exp_q.size() > 0) got = exp_q.pop_front();
        e_chg  = e_poll && (got != m_last);
        if (mon_on) begin
            check_eq("avm_read", bus.avm_read, e_read);
            check_eq("avm_address", bus.avm_address, 0);
            check_eq("rsp_valid", bus.rsp_valid, e_ext);
            check_eq("gnt", bus.gnt, e_ext ? 32'(1 << m_win) : 0);
            if (e_ext) check_eq("rsp_data", bus.rsp_data, got);
            check_eq("change_valid", bus.change_valid, e_chg);
            if (e_chg) begin
                check_eq("change_data", bus.change_data, got);
                check_eq("change_mask", bus.change_mask, got ^ m_last);
            end
        end
        rsp_seen = bus.rsp_valid ? bus.gnt : '0;
        for (int i = 0; i < NUM_REQ; i++) if (rsp_seen[i]) gnt_cnt[i]++;
        if (bus.rsp_valid) rsp_cnt++;
        if (bus.change_valid) begin
            chg_cnt++;
            last_mask = bus.change_mask;
        end
        if (e_read) exp_q.push_back(in_port);
        poll_busy = (m_win == NUM_REQ) && (m_issue_at >= 0) && (cyc >= m_issue_at) && (cyc <= m_done_at);
        if (reset) begin
            m_issue_at = -1;
            m_done_at  = -1;
            m_free_at  = cyc + 1;
            m_win      = 0;
            m_rr       = 0;
            m_cnt      = POLL_DIV - 1;
            m_pend     = 1'b0;
            m_last     = '0;
            exp_q.delete();
        end else begin
            if (e_poll) m_last = got;
            pend_vec = {m_pend, bus.req};
            if (cyc >= m_free_at && pend_vec != '0) begin
                found = 1'b0;
                for (int k = 0; k < SLOTS; k++) begin
                    s = (m_rr + k) % SLOTS;
                    if (!found && pend_vec[s]) begin
                        found = 1'b1;
                        m_win = s;
                    end
                end
                m_rr       = (m_win + 1) % SLOTS;
                m_issue_at = cyc + 1;
                m_done_at  = cyc + 2 + RL;
                m_free_at  = cyc + 3 + RL;
            end
            if (e_poll) m_pend = 1'b0;
            if (!bus.poll_en && !poll_busy) m_pend = 1'b0;
            if (bus.poll_en) begin
                if (m_cnt == 0) begin
                    m_pend = 1'b1;
                    m_cnt  = POLL_DIV - 1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else begin
                m_cnt = POLL_DIV - 1;
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rsp(input int idx, input int budget, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!rsp_seen[idx] && n < budget);
        check_eq($sformatf("rsp_seen_%0d", idx), rsp_seen[idx], 1);
    endtask

    int lat;
    int snap;
    int chg_snap;
    int rsp_snap;

    initial begin
        for (int i = 0; i < NUM_REQ; i++) gnt_cnt[i] = 0;
        reset = 1'b1;
        bus.req = '0;
        bus.poll_en = 1'b0;
        in_port = '0;
        step(2);
        mon_on = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("reset_state", dbg_state, 0);

        // Single request: rsp_valid RL+3 cycles after req is driven.
        in_port = 20'hA5A5A;
        bus.req = 4'b0001;
        wait_rsp(0, 12, lat);
        check_eq("single_latency", lat, RL + 3);
        bus.req = '0;
        step(3);

        // Reset while requester 1 is in WAIT; nothing completes, next grant starts at slot 0.
        bus.req = 4'b0010;
        step(2);
        reset = 1'b1;
        bus.req = '0;
        step(1);
        reset = 1'b0;
        check_eq("reset_midwait_state", dbg_state, 0);
        bus.req = 4'b0011;
        wait_rsp(0, 12, lat);
        check_eq("resume_slot0_lat", lat, RL + 3);
        bus.req = 4'b0010;
        wait_rsp(1, 12, lat);
        bus.req = '0;
        step(3);

        // Fairness with all four requesters holding req.
        snap = gnt_cnt[3];
        bus.req = 4'b1111;
        step(16 * (RL + 3));
        bus.req = '0;
        step(8);
        check_eq("fair_count3", gnt_cnt[3] - snap, 4);

        // Withdrawal: req[2] pulsed while slot 0 is in WAIT.
        snap = gnt_cnt[2];
        bus.req = 4'b0001;
        step(2);
        bus.req = 4'b0101;
        step(1);
        bus.req = 4'b0000;
        step(10);
        check_eq("withdraw_gnt2", gnt_cnt[2] - snap, 0);

        // Poll change detection from a fresh reset baseline.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chg_snap = chg_cnt;
        rsp_snap = rsp_cnt;
        in_port = 20'h00013;
        bus.poll_en = 1'b1;
        step(30);
        check_eq("poll_first_change", chg_cnt - chg_snap, 1);
        check_eq("poll_first_mask", last_mask, 20'h00013);
        check_eq("poll_no_rsp", rsp_cnt - rsp_snap, 0);
        chg_snap = chg_cnt;
        in_port = 20'h00000;
        step(20);
        check_eq("poll_second_change", chg_cnt - chg_snap, 1);
        check_eq("poll_second_mask", last_mask, 20'h00013);

        // Poll competing with two held requesters.
        bus.req = 4'b0011;
        in_port = 20'h0F0F0;
        step(60);
        bus.req = '0;
        step(6);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            step(1);
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) bus.poll_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 2))
                    0:       in_port = 20'h00013;
                    1:       in_port = 20'hA5A5A;
                    default: in_port = 20'($urandom);
                endcase
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i]) begin
                    if (rsp_seen[i] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0))
                        bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                end
            end
        end
        reset = 1'b0;
        bus.req = '0;
        bus.poll_en = 1'b0;
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pio_read_scheduler.md
Name: pio_read_scheduler

Overview:
Sequences read accesses to the 20-bit input PIO slave (Avalon-MM, one-cycle registered readdata) and shares it among NUM_REQ requesters through round-robin arbitration. Runs an internal periodic poll in one extra arbitration slot. Compares each poll result with the previous poll result and emits a change event with a bit mask. Sits between the HPS-side control logic and the PIO slave, in the same clock domain.

Parameters:
NUM_REQ, 4, number of external requesters (1..8)
DATA_W, 20, width of PIO input data
READ_LATENCY, 1, cycles from avm_read issue to valid avm_readdata (1..4)
POLL_DIV, 1000, cycles between auto-poll requests (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester read request, level; held until matching gnt/rsp_valid
gnt  out  NUM_REQ  one-hot requester identifier, valid only while rsp_valid=1
rsp_valid  out  1  one-cycle pulse: rsp_data valid for requester gnt
rsp_data  out  DATA_W  captured PIO value
avm_address  out  2  slave address, always 0
avm_read  out  1  read strobe, one cycle per access
avm_readdata  in  32  slave read data; bits [DATA_W-1:0] used
poll_en  in  1  enables periodic polling
change_valid  out  1  one-cycle pulse: poll value differs from previous poll value
change_data  out  DATA_W  new poll value, valid with change_valid
change_mask  out  DATA_W  XOR of new and previous poll values

Behaviour:
- Reset: all outputs 0. FSM in IDLE. RR pointer 0. last_poll 0. poll_pending 0. Poll counter loaded with POLL_DIV-1. Any in-flight access is abandoned; no rsp_valid or change_valid for it.
- Slots: 0..NUM_REQ-1 are the external req bits; slot NUM_REQ is poll_pending.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: if any slot is pending, select the winner by round-robin. Search starts at the RR pointer and wraps over NUM_REQ+1 slots. Register the winner; next state ISSUE. If nothing is pending, stay in IDLE.
- ISSUE: avm_read=1, avm_address=0 for exactly 1 cycle. Load the latency counter with READ_LATENCY; next state WAIT.
- WAIT: decrement the counter. When it reaches 0, capture avm_readdata[DATA_W-1:0] at the clock edge; next state DONE.
- DONE, external winner: rsp_valid=1, gnt=onehot(winner), rsp_data=captured value.
- DONE, poll winner: clear poll_pending. If captured != last_poll, pulse change_valid with change_data and change_mask. Update last_poll. rsp_valid stays 0.
- DONE, both cases: RR pointer = (winner+1) mod (NUM_REQ+1). Next state IDLE.
- Latency: req sampled in IDLE at cycle c -> avm_read in c+1 -> rsp_valid in c+2+READ_LATENCY. With READ_LATENCY=1, request to rsp_valid takes 3 cycles; one access per READ_LATENCY+3 cycles.
- Request withdrawal: req dropped before the IDLE sample is simply not granted. Once a request is granted, it completes regardless of req.
- Continuous request: a requester holding req after rsp_valid is treated as a new request, arbitrated against others in the next IDLE.
- Poll timer: when poll_en=1, the counter decrements each cycle. At 0 it sets poll_pending and reloads POLL_DIV-1.
- Poll coalescing: an expiry while poll_pending=1 coalesces into the existing pending poll (no queueing).
- poll_en=0: counter held at POLL_DIV-1, and poll_pending is cleared if not already granted. A poll already in ISSUE/WAIT/DONE completes normally.
- Timer expiry and DONE of a poll in the same cycle: the pending flag ends up set, so the new expiry wins over the clear.
- Change detection baseline: the first poll after reset compares against 0.
- avm_readdata is ignored outside the capture cycle. Bits above DATA_W-1 are ignored.

Test Plan:
- Reset mid-WAIT (req[1]=1, reset asserted in WAIT) -> no rsp_valid; all outputs 0 the cycle after reset; next grant resumes from slot 0.
- Single request: req=4'b0001, PIO in_port=20'hA5A5A, READ_LATENCY=1, poll_en=0 -> avm_read pulse 1 cycle, avm_address=0; rsp_valid 3 cycles after req sampled; gnt=4'b0001; rsp_data=20'hA5A5A.
- Fairness: req=4'b1111 held continuously, poll_en=0 -> grant order 0,1,2,3,0,... with exactly one avm_read per 4 cycles and no slot granted twice before the others.
- Poll change: POLL_DIV=8, poll_en=1, in_port 0 then 20'h00013 -> first poll: change_valid=1, change_mask=20'h00013; next poll with same value: no change_valid; no rsp_valid for either poll.
- Poll vs. requesters: POLL_DIV=4, req=4'b0011 held -> poll slot granted within one full rotation (slot order 0,1,poll); no extra poll accesses queued from coalesced expiries.
- Withdrawal: req[2] pulsed for 1 cycle while a slot-0 access is in WAIT -> req[2] never granted; no spurious gnt.
